// File: rtl/dawg_partitioned_set.sv
// dawg_partitioned_set
// One set of a DAWG-style way-partitioned cache. The OS assigns each
// protection domain a way mask. A user lookup can only hit in, fill into,
// or advance round-robin state for ways inside its own domain's mask. This
// keeps each domain's footprint invisible to the others.
//
// Ports
//   clk        clock, all state updates on posedge
//   reset      asynchronous, active-low reset
//   os_req     OS way-mask write request
//   os_domain  domain whose mask is written
//   os_hitmap  new way mask for os_domain
//   user_req   lookup request
//   user_dom   requesting domain
//   user_tag   tag looked up
//   ready      block can accept a request this cycle (IDLE)
//   resp_valid one-cycle pulse, hit/hit_way valid
//   hit        lookup hit
//   hit_way    hit way, or the way filled on a miss (0 if no fill)
//   os_err     one-cycle pulse, OS write rejected (mask overlap)
//   dbg_state  current FSM state, for observation only
//
// Handshake: a request is taken on a posedge where ready=1 and its req is
// high. os_req has priority: if both are high, only the OS write is taken.
// The requester must then hold user_req until a later edge with ready=1 and
// os_req=0 accepts it. Responses and errors arrive as registered one-cycle
// pulses, and nothing combinational runs from inputs to outputs.
module dawg_partitioned_set #(
  parameter int NUM_WAYS    = 4,
  parameter int NUM_DOMAINS = 2,
  parameter int TAG_WIDTH   = 8,
  localparam int DOM_W      = $clog2(NUM_DOMAINS),
  localparam int WAY_W      = $clog2(NUM_WAYS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 os_req,
  input  logic [DOM_W-1:0]     os_domain,
  input  logic [NUM_WAYS-1:0]  os_hitmap,
  input  logic                 user_req,
  input  logic [DOM_W-1:0]     user_dom,
  input  logic [TAG_WIDTH-1:0] user_tag,
  output logic                 ready,
  output logic                 resp_valid,
  output logic                 hit,
  output logic [WAY_W-1:0]     hit_way,
  output logic                 os_err,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_WAYS-1:0]  mask_q [NUM_DOMAINS];
  logic [NUM_WAYS-1:0]  valid_q;
  logic [TAG_WIDTH-1:0] tag_q  [NUM_WAYS];
  logic [WAY_W-1:0]     rr_q   [NUM_DOMAINS];

  // Latched lookup request
  logic [DOM_W-1:0]     l_dom_q;
  logic [TAG_WIDTH-1:0] l_tag_q;

  // Flush context: domain, its mask before the write, and the sweep index
  logic [DOM_W-1:0]     f_dom_q;
  logic [NUM_WAYS-1:0]  f_old_q;
  logic [WAY_W-1:0]     f_idx_q;

  logic                 os_acc, user_acc, os_conflict;
  logic [NUM_WAYS-1:0]  cur_mask;
  logic [WAY_W-1:0]     cur_rr;
  logic                 lk_hit, inv_found, ge_found, can_fill;
  logic [WAY_W-1:0]     lk_way, inv_way, ge_way, any_way, victim, victim_next;

  assign ready     = (state_q == S_IDLE);
  assign dbg_state = state_q;

  // Request acceptance and overlap check against every other domain's mask
  always_comb begin
    os_acc      = (state_q == S_IDLE) && os_req;
    user_acc    = (state_q == S_IDLE) && user_req && !os_req;
    os_conflict = 1'b0;
    for (int d = 0; d < NUM_DOMAINS; d++) begin
      if ((DOM_W'(d) != os_domain) && ((os_hitmap & mask_q[d]) != '0))
        os_conflict = 1'b1;
    end
  end

  // Hit and victim selection, restricted to the requesting domain's mask.
  // Scanning downwards makes the last match the lowest-numbered way.
  always_comb begin
    cur_mask  = mask_q[l_dom_q];
    cur_rr    = rr_q[l_dom_q];
    lk_hit    = 1'b0;
    lk_way    = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    ge_found  = 1'b0;
    ge_way    = '0;
    any_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (cur_mask[w]) begin
        any_way = WAY_W'(w);
        if (WAY_W'(w) >= cur_rr) begin
          ge_found = 1'b1;
          ge_way   = WAY_W'(w);
        end
        if (!valid_q[w]) begin
          inv_found = 1'b1;
          inv_way   = WAY_W'(w);
        end
        if (valid_q[w] && (tag_q[w] == l_tag_q)) begin
          lk_hit = 1'b1;
          lk_way = WAY_W'(w);
        end
      end
    end
    // No owned way at/after the pointer means the search wraps to the
    // lowest owned way.
    victim      = inv_found ? inv_way : (ge_found ? ge_way : any_way);
    victim_next = (victim == WAY_W'(NUM_WAYS - 1)) ? '0 : victim + WAY_W'(1);
    can_fill    = |cur_mask;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (os_acc && !os_conflict) state_d = S_FLUSH;
        else if (user_acc)          state_d = S_LOOKUP;
      end
      S_LOOKUP: state_d = S_IDLE;
      S_FLUSH:  if (f_idx_q == WAY_W'(NUM_WAYS - 1)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < NUM_DOMAINS; d++) begin
        mask_q[d] <= '0;
        rr_q[d]   <= '0;
      end
      for (int w = 0; w < NUM_WAYS; w++) tag_q[w] <= '0;
      valid_q    <= '0;
      l_dom_q    <= '0;
      l_tag_q    <= '0;
      f_dom_q    <= '0;
      f_old_q    <= '0;
      f_idx_q    <= '0;
      resp_valid <= 1'b0;
      hit        <= 1'b0;
      hit_way    <= '0;
      os_err     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      os_err     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (os_acc) begin
            if (os_conflict) begin
              os_err <= 1'b1;
            end else begin
              mask_q[os_domain] <= os_hitmap;
              rr_q[os_domain]   <= '0;
              f_dom_q           <= os_domain;
              f_old_q           <= mask_q[os_domain];
              f_idx_q           <= '0;
            end
          end else if (user_acc) begin
            l_dom_q <= user_dom;
            l_tag_q <= user_tag;
          end
        end
        S_LOOKUP: begin
          resp_valid <= 1'b1;
          hit        <= lk_hit;
          if (lk_hit) begin
            hit_way <= lk_way;
          end else if (can_fill) begin
            hit_way         <= victim;
            tag_q[victim]   <= l_tag_q;
            valid_q[victim] <= 1'b1;
            rr_q[l_dom_q]   <= victim_next;
          end else begin
            hit_way <= '0;
          end
        end
        S_FLUSH: begin
          // Only ways the domain gave up are invalidated; retained ways keep
          // their contents.
          if (f_old_q[f_idx_q] && !mask_q[f_dom_q][f_idx_q])
            valid_q[f_idx_q] <= 1'b0;
          f_idx_q <= f_idx_q + WAY_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dawg_partitioned_set.sv
// tb_dawg_partitioned_set
// Directed scenarios followed by randomized OS writes and lookups. A
// behavioural model of the set (mask/valid/tag/pointer arrays) predicts every
// response.
module tb_dawg_partitioned_set;
  localparam int NW = 4;
  localparam int ND = 2;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          os_req = 1'b0;
  logic [0:0]    os_domain = '0;
  logic [NW-1:0] os_hitmap = '0;
  logic          user_req = 1'b0;
  logic [0:0]    user_dom = '0;
  logic [TW-1:0] user_tag = '0;
  logic          ready, resp_valid, hit, os_err;
  logic [1:0]    hit_way;
  logic [1:0]    dbg_state;

  dawg_partitioned_set #(.NUM_WAYS(NW), .NUM_DOMAINS(ND), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .os_req(os_req), .os_domain(os_domain), .os_hitmap(os_hitmap),
    .user_req(user_req), .user_dom(user_dom), .user_tag(user_tag),
    .ready(ready), .resp_valid(resp_valid), .hit(hit), .hit_way(hit_way),
    .os_err(os_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int compared = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];

  logic [NW-1:0] m_mask [ND];
  bit            m_valid[NW];
  logic [TW-1:0] m_tag  [NW];
  int            m_rr   [ND];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_mask[d] = '0;
      m_rr[d] = 0;
    end
    for (int w = 0; w < NW; w++) begin
      m_valid[w] = 1'b0;
      m_tag[w] = '0;
    end
  endtask

  function automatic bit model_conflict(input int d, input logic [NW-1:0] map);
    bit c = 1'b0;
    for (int o = 0; o < ND; o++)
      if (o != d && (map & m_mask[o]) != '0) c = 1'b1;
    return c;
  endfunction

  task automatic model_os(input int d, input logic [NW-1:0] map);
    for (int w = 0; w < NW; w++)
      if (m_mask[d][w] && !map[w]) m_valid[w] = 1'b0;
    m_mask[d] = map;
    m_rr[d] = 0;
  endtask

  task automatic model_lookup(input int d, input logic [TW-1:0] t,
                              output bit eh, output int ew);
    int v;
    int c;
    eh = 1'b0;
    ew = 0;
    v = -1;
    for (int w = 0; w < NW; w++)
      if (!eh && m_mask[d][w] && m_valid[w] && m_tag[w] == t) begin
        eh = 1'b1;
        ew = w;
      end
    if (!eh && m_mask[d] != '0) begin
      for (int w = 0; w < NW; w++)
        if (v < 0 && m_mask[d][w] && !m_valid[w]) v = w;
      for (int k = 0; k < NW; k++) begin
        c = (m_rr[d] + k) % NW;
        if (v < 0 && m_mask[d][c]) v = c;
      end
      m_tag[v] = t;
      m_valid[v] = 1'b1;
      m_rr[d] = (v + 1) % NW;
      ew = v;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_lookup(input int d, input logic [TW-1:0] t);
    bit eh;
    int ew;
    logic [7:0] e;
    chk("lookup_ready_before", ready, 1);
    user_req = 1'b1;
    user_dom = d[0:0];
    user_tag = t;
    @(posedge clk); #1;
    user_req = 1'b0;
    chk("lookup_ready_busy", ready, 0);
    chk("lookup_resp_early", resp_valid, 0);
    model_lookup(d, t, eh, ew);
    exp_q.push_back({5'b0, eh, ew[1:0]});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk("lookup_resp_valid", resp_valid, 1);
    chk("lookup_hit", hit, e[2]);
    chk("lookup_hit_way", hit_way, e[1:0]);
    chk("lookup_ready_after", ready, 1);
  endtask

  task automatic os_write(input int d, input logic [NW-1:0] map);
    bit ee;
    ee = model_conflict(d, map);
    chk("os_ready_before", ready, 1);
    os_req = 1'b1;
    os_domain = d[0:0];
    os_hitmap = map;
    @(posedge clk); #1;
    os_req = 1'b0;
    if (ee) begin
      chk("os_err_pulse", os_err, 1);
      chk("os_err_ready", ready, 1);
      @(posedge clk); #1;
      chk("os_err_clear", os_err, 0);
    end else begin
      model_os(d, map);
      chk("os_no_err", os_err, 0);
      for (int i = 0; i < NW; i++) begin
        chk("flush_ready_low", ready, 0);
        chk("flush_no_resp", resp_valid, 0);
        @(posedge clk); #1;
      end
      chk("flush_ready_back", ready, 1);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_hit", hit, 0);
    chk("rst_hit_way", hit_way, 0);
    chk("rst_os_err", os_err, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    // 1: reset, then lookup with empty mask
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs();
    do_lookup(0, 8'h12);

    // 2: grant ways 0,1 to dom0; miss then hit
    os_write(0, 4'b0011);
    do_lookup(0, 8'h12);
    do_lookup(0, 8'h12);

    // 3: clean mask, fill A,B,C (way0, way1, RR-evict way0), A misses
    os_write(0, 4'b0000);
    os_write(0, 4'b0011);
    do_lookup(0, 8'h0A);
    do_lookup(0, 8'h0B);
    do_lookup(0, 8'h0C);
    do_lookup(0, 8'h0A);

    // 4: overlapping grant rejected, disjoint grant accepted
    os_write(1, 4'b0110);
    os_write(1, 4'b1100);

    // 5: dom1 cannot see dom0's tag; dom0 still hits
    do_lookup(1, 8'h0C);
    do_lookup(0, 8'h0C);
    do_lookup(0, 8'h0A);

    // 6a: simultaneous requests, OS first, user held through flush
    user_req = 1'b1;
    user_dom = 1'b1;
    user_tag = 8'h55;
    os_write(0, 4'b0001);
    chk("held_user_not_taken", resp_valid, 0);
    do_lookup(1, 8'h55);
    do_lookup(0, 8'h0C);

    // 6b: reset in the middle of FLUSH
    os_req = 1'b1;
    os_domain = 1'b1;
    os_hitmap = 4'b1000;
    @(posedge clk); #1;
    os_req = 1'b0;
    chk("flush_started", ready, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    do_lookup(1, 8'h55);
    os_write(0, 4'b0011);
    do_lookup(0, 8'h12);

    // reset in the middle of LOOKUP: no response, no fill
    user_req = 1'b1;
    user_dom = 1'b0;
    user_tag = 8'h77;
    @(posedge clk); #1;
    user_req = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    @(posedge clk); #1;
    chk("lookup_abort_no_resp", resp_valid, 0);
    reset = 1'b1;
    os_write(0, 4'b0011);
    do_lookup(0, 8'h77);

    // randomized mix
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) < 2)
        os_write($urandom_range(0, ND - 1), NW'($urandom_range(0, 15)));
      else
        do_lookup($urandom_range(0, ND - 1), TW'($urandom_range(0, 5)));
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
